// File: rtl/perf_counter_bank_if.sv
// Control, event and snapshot-read signals of the performance counter bank.
// The CPU-side block drives through the master modport; the bank uses the slave modport.
interface perf_counter_bank_if #(
    parameter int CNT_W    = 16,
    parameter int OPCODE_W = 4,
    parameter int FUNC_W   = 3
);
    logic                count_en;
    logic                clear;
    logic                fetch_en;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC_W-1:0]   func;
    logic                stall;
    logic                snap;
    logic [2:0]          rd_sel;
    logic [CNT_W-1:0]    rd_data;
    logic                ovf_any;

    modport master (
        output count_en, clear, fetch_en, opcode, func, stall, snap, rd_sel,
        input  rd_data, ovf_any
    );

    modport slave (
        input  count_en, clear, fetch_en, opcode, func, stall, snap, rd_sel,
        output rd_data, ovf_any
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Performance-monitor bank: seven live event counters with sticky overflow
// flags, a global freeze/clear, and an atomically captured snapshot bank
// read through a combinational mux.
module perf_counter_bank #(
    parameter int CNT_W    = 16,
    parameter int SATURATE = 1,
    parameter int OPCODE_W = 4,
    parameter int FUNC_W   = 3
) (
    input logic               clk,
    input logic               reset,
    perf_counter_bank_if.slave bus
);
    // Counter indices: CYC, INSTR, LOAD, STORE, ALU, CTRL, STALL.
    localparam int NCNT = 7;

    logic [NCNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCNT-1:0]            ovf_q, ovf_d;
    // Word 7 of the snapshot bank holds the overflow vector.
    logic [7:0][CNT_W-1:0]      snap_q, snap_d;

    logic [NCNT-1:0] inc;
    logic            is_alu, is_ld, is_st, is_ctrl;

    // Instruction class decode and per-counter increment requests.
    always_comb begin
        is_alu  = ((bus.opcode == OPCODE_W'(0)) && (bus.func <= FUNC_W'(4))) ||
                  (bus.opcode == OPCODE_W'(2)) || (bus.opcode == OPCODE_W'(3));
        is_ld   = (bus.opcode == OPCODE_W'(4));
        is_st   = (bus.opcode == OPCODE_W'(5));
        is_ctrl = (bus.opcode == OPCODE_W'(1)) || (bus.opcode == OPCODE_W'(6)) ||
                  (bus.opcode == OPCODE_W'(7)) || (bus.opcode == OPCODE_W'(8));
        inc[0]  = 1'b1;
        inc[1]  = bus.fetch_en;
        inc[2]  = bus.fetch_en & is_ld;
        inc[3]  = bus.fetch_en & is_st;
        inc[4]  = bus.fetch_en & is_alu;
        inc[5]  = bus.fetch_en & is_ctrl;
        inc[6]  = bus.stall;
    end

    // Live counter update: clear beats increment; all-ones either holds or wraps.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (bus.clear) begin
            cnt_d = '0;
            ovf_d = '0;
        end else if (bus.count_en) begin
            for (int i = 0; i < NCNT; i++) begin
                if (inc[i]) begin
                    if (&cnt_q[i]) begin
                        ovf_d[i] = 1'b1;
                        cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Snapshot capture takes pre-edge live values, so snap+clear reads then resets.
    always_comb begin
        snap_d = snap_q;
        if (bus.snap) begin
            for (int i = 0; i < NCNT; i++) begin
                snap_d[i] = cnt_q[i];
            end
            snap_d[7] = CNT_W'(ovf_q);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            ovf_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            snap_q <= snap_d;
        end
    end

    assign bus.rd_data = snap_q[bus.rd_sel];
    assign bus.ovf_any = |ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: three instances (16-bit saturating,
// 8-bit saturating, 8-bit wrapping) share one stimulus stream; expected reads
// are queued by the stimulus and checked by a monitor at the falling edge.
module tb_perf_counter_bank;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       count_en = 1'b0, clear = 1'b0, fetch_en = 1'b0, stall = 1'b0, snap = 1'b0;
    logic [3:0] opcode = '0;
    logic [2:0] func = '0;
    logic [2:0] rd_sel = '0;
    logic       chk_vld = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    perf_counter_bank_if #(.CNT_W(16)) if16 ();
    perf_counter_bank_if #(.CNT_W(8))  if_s8 ();
    perf_counter_bank_if #(.CNT_W(8))  if_w8 ();

    `define DRIVE_IF(IFN) \
        assign IFN.count_en = count_en; assign IFN.clear = clear; \
        assign IFN.fetch_en = fetch_en; assign IFN.opcode = opcode; \
        assign IFN.func = func; assign IFN.stall = stall; \
        assign IFN.snap = snap; assign IFN.rd_sel = rd_sel;
    `DRIVE_IF(if16)
    `DRIVE_IF(if_s8)
    `DRIVE_IF(if_w8)
    `undef DRIVE_IF

    perf_counter_bank #(.CNT_W(16), .SATURATE(1)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));
    perf_counter_bank #(.CNT_W(8),  .SATURATE(1)) u_dut_s8 (.clk(clk), .reset(reset), .bus(if_s8));
    perf_counter_bank #(.CNT_W(8),  .SATURATE(0)) u_dut_w8 (.clk(clk), .reset(reset), .bus(if_w8));

    // dut: 0 = 16-bit sat, 1 = 8-bit sat, 2 = 8-bit wrap; kind: 0 = rd_data, 1 = ovf_any
    typedef struct {
        int          dut;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sbq[$];

    // Monitor: on every strobed cycle, drain and compare all queued expectations.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (chk_vld) begin
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                case (e.dut)
                    0:       act = (e.kind == 0) ? 32'(if16.rd_data)  : 32'(if16.ovf_any);
                    1:       act = (e.kind == 0) ? 32'(if_s8.rd_data) : 32'(if_s8.ovf_any);
                    default: act = (e.kind == 0) ? 32'(if_w8.rd_data) : 32'(if_w8.ovf_any);
                endcase
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int k, input logic [31:0] v, input string nm);
        exp_t e;
        e.dut = d; e.kind = k; e.exp = v; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic strobe();
        chk_vld = 1'b1;
        step(1);
        chk_vld = 1'b0;
    endtask

    task automatic rd(input int d, input logic [2:0] sel, input logic [31:0] v, input string nm);
        rd_sel = sel;
        push(d, 0, v, nm);
        strobe();
    endtask

    task automatic ov(input int d, input logic v, input string nm);
        push(d, 1, 32'(v), nm);
        strobe();
    endtask

    task automatic do_snap();
        snap = 1'b1; step(1); snap = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; step(1); clear = 1'b0;
    endtask

    task automatic run(input int n);
        count_en = 1'b1; step(n); count_en = 1'b0;
    endtask

    logic [3:0]  ops [10] = '{4'h4, 4'h5, 4'h2, 4'h0, 4'h6, 4'h0, 4'hF, 4'h4, 4'h3, 4'h1};
    logic [2:0]  fns [10] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [31:0] exp1 [8] = '{32'd10, 32'd10, 32'd2, 32'd1, 32'd3, 32'd2, 32'd0, 32'd0};

    initial begin
        step(3);
        reset = 1'b1;
        step(1);

        // reset state
        rd(0, 3'd0, 32'd0, "rst_cyc");
        rd(0, 3'd7, 32'd0, "rst_flags");
        ov(0, 1'b0, "rst_ovf_any");

        // test 1: instruction mix
        count_en = 1'b1; fetch_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            opcode = ops[i]; func = fns[i];
            step(1);
        end
        count_en = 1'b0; fetch_en = 1'b0; opcode = '0; func = '0;
        do_snap();
        for (int i = 0; i < 8; i++)
            rd(0, 3'(i), exp1[i], $sformatf("mix_sel%0d", i));

        // test 2: stalls, then frozen window
        do_clear();
        count_en = 1'b1; stall = 1'b1;
        step(4);
        stall = 1'b0;
        step(2);
        count_en = 1'b0;
        do_snap();
        rd(0, 3'd0, 32'd6, "stall_cyc");
        rd(0, 3'd6, 32'd4, "stall_cnt");
        rd(0, 3'd1, 32'd0, "stall_instr");
        stall = 1'b1; fetch_en = 1'b1; opcode = 4'h4;
        step(5);
        stall = 1'b0; fetch_en = 1'b0; opcode = '0;
        do_snap();
        rd(0, 3'd0, 32'd6, "frz_cyc");
        rd(0, 3'd6, 32'd4, "frz_stall");
        rd(0, 3'd2, 32'd0, "frz_load");

        // test 3: overflow, saturate vs wrap
        do_clear();
        run(260);
        do_snap();
        rd(1, 3'd0, 32'd255, "sat8_cyc");
        rd(1, 3'd7, 32'd1,   "sat8_flags");
        ov(1, 1'b1, "sat8_ovf_any");
        rd(2, 3'd0, 32'd4,   "wrap8_cyc");
        rd(2, 3'd7, 32'd1,   "wrap8_flags");
        ov(2, 1'b1, "wrap8_ovf_any");
        rd(0, 3'd0, 32'd260, "w16_cyc");
        ov(0, 1'b0, "w16_ovf_any");

        // test 4: atomic snap + clear
        do_clear();
        run(20);
        snap = 1'b1; clear = 1'b1; count_en = 1'b1;
        step(1);
        snap = 1'b0; clear = 1'b0;
        step(1);
        count_en = 1'b0;
        rd(0, 3'd0, 32'd20, "sc_snap_cyc");
        rd(1, 3'd0, 32'd20, "sc_snap_cyc8");
        rd(0, 3'd7, 32'd0,  "sc_snap_flags");
        ov(0, 1'b0, "sc_ovf_any16");
        ov(1, 1'b0, "sc_ovf_any8");
        do_snap();
        rd(0, 3'd0, 32'd1, "sc_next_cyc");

        // test 5: asynchronous reset between edges
        do_clear();
        fetch_en = 1'b1; opcode = 4'h4;
        run(258);
        fetch_en = 1'b0; opcode = '0;
        do_snap();
        rd(0, 3'd0, 32'd258, "pre_rst_cyc");
        rd(0, 3'd2, 32'd258, "pre_rst_load");
        ov(1, 1'b1, "pre_rst_ovf8");
        #1;
        reset = 1'b0;
        rd_sel = 3'd0;
        push(0, 0, 32'd0, "arst_cyc16");
        push(1, 0, 32'd0, "arst_cyc8");
        push(1, 1, 32'd0, "arst_ovf_any8");
        push(2, 1, 32'd0, "arst_ovf_any_w8");
        chk_vld = 1'b1;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        reset = 1'b1;
        step(1);
        do_snap();
        rd(0, 3'd0, 32'd0, "post_rst_cyc");
        rd(0, 3'd2, 32'd0, "post_rst_load");
        rd(1, 3'd7, 32'd0, "post_rst_flags8");

        step(2);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised performance-monitor bank for the multicycle CPU. Counts cycles, retired-fetch instructions, loads, stores, ALU ops, control-flow ops and stall cycles.
- Adds three capabilities: selectable saturate/wrap overflow with sticky flags, a global freeze/clear, and an atomic snapshot register file read through a mux port.
- Sits beside the fetch/decode stage and is fed the same fetch_en, opcode and func signals the datapath decodes.

Parameters:
- CNT_W, 16, width of every counter and of rd_data; legal range 8..32.
- SATURATE, 1, 1 = counters stick at all-ones on overflow; 0 = counters wrap to 0.
- OPCODE_W, 4, opcode width.
- FUNC_W, 3, R-type func width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- count_en  in  1  1 = counters advance; 0 = all live counters frozen.
- clear  in  1  synchronous clear of live counters and overflow flags.
- fetch_en  in  1  an instruction is fetched this cycle.
- opcode  in  OPCODE_W  opcode of the fetched instruction.
- func  in  FUNC_W  func field, meaningful when opcode = 0000.
- stall  in  1  pipeline/FSM stall indicator.
- snap  in  1  copy all live counters and flags into the snapshot bank.
- rd_sel  in  3  snapshot read index.
- rd_data  out  CNT_W  selected snapshot word.
- ovf_any  out  1  OR of live sticky overflow flags.

Behaviour:
- Live counters, index 0..6: CYC, INSTR, LOAD, STORE, ALU, CTRL, STALL. Each is CNT_W bits.
- Each counter has a sticky ovf bit, giving a 7-bit ovf vector.
- Reset (reset = 0, asynchronous): every live counter, ovf bit and snapshot word goes to 0. Outputs: rd_data = 0, ovf_any = 0.
- Increment conditions apply only when count_en = 1 and clear = 0:
  - CYC: every cycle.
  - STALL: when stall = 1.
  - INSTR: when fetch_en = 1.
  - Class counters: when fetch_en = 1 and the opcode decodes to that class.
- Class decode:
  - ALU: opcode 0000 with func 000..100, or opcode 0010 or 0011.
  - LOAD: opcode 0100.
  - STORE: opcode 0101.
  - CTRL: opcode 0001, 0110, 0111 or 1000.
  - Anything else (including opcode 0000 with func 101..111) increments INSTR only.
  - At most one class counter increments per cycle.
- Overflow, when a counter at all-ones is incremented:
  - SATURATE = 1: the counter holds all-ones.
  - SATURATE = 0: the counter becomes 0.
  - In both modes its ovf bit sets and stays set until clear or reset.
  - Once saturated, further increments keep the flag set and the value unchanged.
- count_en = 0: all live counters and flags hold. clear and snap still act.
- clear = 1: next edge, all live counters and ovf bits go to 0, regardless of count_en, fetch_en or stall. Clear wins over increment, so counters read 0, not 1. The snapshot bank is untouched.
- snap = 1: next edge, each snapshot word takes the live value present before that edge's increment. Snapshot index 7 takes the ovf vector zero-extended to CNT_W.
- snap and clear in the same cycle: the snapshot captures pre-clear values; live counters clear. This is the atomic read-and-reset idiom.
- rd_data is combinational from the snapshot bank, indexed by rd_sel (0..6 counters, 7 flags). There is zero-cycle read latency from rd_sel, and rd_data is stable between snaps.
- ovf_any is combinational OR of the live ovf vector.
- Reset asserted mid-count: immediate clear of all state. Counting resumes on the first rising edge after reset deasserts.

Test Plan:
1. Reset, then count_en = 1 for 10 cycles with fetch_en = 1 and opcodes 0100, 0101, 0010, 0000/func 001, 0110, 0000/func 110, 1111, 0100, 0011, 0001; then snap.
   → CYC = 10, INSTR = 10, LOAD = 2, STORE = 1, ALU = 3, CTRL = 2, STALL = 0.
2. stall = 1 for 4 of 6 cycles, then hold count_en = 0 for 5 cycles, then snap.
   → CYC = 6, STALL = 4, and no change across the frozen window.
3. SATURATE = 1, CNT_W = 8: run 260 cycles, snap.
   → CYC = 255, rd_sel 7 gives bit0 = 1, ovf_any = 1.
   Repeat with SATURATE = 0 → CYC = 4, bit0 = 1.
4. Accumulate CYC = 20, then assert snap and clear in the same cycle.
   → Snapshot CYC = 20, live counters 0, ovf_any = 0. One later snap reads CYC = 1.
5. Assert reset low asynchronously between clock edges while counters are non-zero.
   → rd_data and ovf_any go to 0 without a clock edge, and the first post-reset snap reads all 0.
